// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer and its pipeline.
package mac_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StDrain,
    StRead,
    StDone
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 3;
  localparam int unsigned DrainCntW    = 2;

  // Address width for a flattened index space; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mac_pipe.sv
// Two-stage multiply-accumulate pipeline with valid/tag shift path and C write-back.
module mac_pipe #(
  parameter int unsigned DATA_WIDTH_INITIAL = 8,
  parameter int unsigned DATA_WIDTH_FINAL   = 16,
  parameter int unsigned CW                 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue,
  input  logic                          first,
  input  logic                          last,
  input  logic [CW-1:0]                 c_idx,
  input  logic [DATA_WIDTH_INITIAL-1:0] a_data_in,
  input  logic [DATA_WIDTH_INITIAL-1:0] b_data_in,
  output logic                          c_we,
  output logic [CW-1:0]                 c_addr,
  output logic [DATA_WIDTH_FINAL-1:0]   c_data_out
);

  logic                        s1_valid_q, s1_first_q, s1_last_q;
  logic [CW-1:0]               s1_idx_q;
  logic                        s2_valid_q, s2_first_q, s2_last_q;
  logic [CW-1:0]               s2_idx_q;
  logic [DATA_WIDTH_FINAL-1:0] prod_d, prod_q;
  logic [DATA_WIDTH_FINAL-1:0] acc_sum, acc_q;
  logic                        c_we_q;
  logic [CW-1:0]               c_addr_q;
  logic [DATA_WIDTH_FINAL-1:0] c_data_q;

  always_comb begin
    prod_d  = DATA_WIDTH_FINAL'(a_data_in) * DATA_WIDTH_FINAL'(b_data_in);
    // First term of a dot product restarts the accumulator; wraps modulo 2^width.
    acc_sum = (s2_first_q ? '0 : acc_q) + prod_q;
  end

  // Stage 1: tags wait one cycle for the memory's registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= issue;
      s1_first_q <= first;
      s1_last_q  <= last;
      s1_idx_q   <= c_idx;
    end
  end

  // Stage 2: product register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_idx_q   <= '0;
      prod_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_idx_q   <= s1_idx_q;
      if (s1_valid_q) begin
        prod_q <= prod_d;
      end
    end
  end

  // Stage 3: accumulate and emit the finished element on the last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      c_we_q   <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
    end else if (s2_valid_q) begin
      acc_q  <= acc_sum;
      c_we_q <= s2_last_q;
      if (s2_last_q) begin
        c_addr_q <= s2_idx_q;
        c_data_q <= acc_sum;
      end
    end else begin
      c_we_q <= 1'b0;
    end
  end

  assign c_we       = c_we_q;
  assign c_addr     = c_addr_q;
  assign c_data_out = c_data_q;

endmodule

// File: rtl/mac_sequencer.sv
// Matrix-multiply controller: loads A/B, streams element pairs into a MAC pipeline,
// writes back C and requests a C readout.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned param_M            = 4,
  parameter int unsigned param_K            = 4,
  parameter int unsigned param_N            = 4,
  parameter int unsigned DATA_WIDTH_INITIAL = 8,
  parameter int unsigned DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
  localparam int unsigned AW = addr_w(param_M * param_K),
  localparam int unsigned BW = addr_w(param_K * param_N),
  localparam int unsigned CW = addr_w(param_M * param_N)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          a_b_we,
  output logic                          a_b_re,
  output logic [AW-1:0]                 a_addr,
  output logic [BW-1:0]                 b_addr,
  input  logic [DATA_WIDTH_INITIAL-1:0] a_data_in,
  input  logic [DATA_WIDTH_INITIAL-1:0] b_data_in,
  output logic                          c_we,
  output logic [CW-1:0]                 c_addr,
  output logic [DATA_WIDTH_FINAL-1:0]   c_data_out,
  output logic                          c_re
);

  localparam int unsigned IW = addr_w(param_M);
  localparam int unsigned JW = addr_w(param_N);
  localparam int unsigned KW = addr_w(param_K);

  state_e                 state_q, state_d;
  logic [IW-1:0]          i_q;
  logic [JW-1:0]          j_q;
  logic [KW-1:0]          k_q;
  logic [DrainCntW-1:0]   drain_q;
  logic                   i_last, j_last, k_last, issue_last, drain_last;
  logic [CW-1:0]          c_idx;

  assign i_last     = (i_q == IW'(param_M - 1));
  assign j_last     = (j_q == JW'(param_N - 1));
  assign k_last     = (k_q == KW'(param_K - 1));
  assign issue_last = i_last && j_last && k_last;
  assign drain_last = (drain_q == DrainCntW'(DRAIN_CYCLES - 1));
  assign c_idx      = CW'(32'(i_q) * param_N + 32'(j_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StLoad;
      StLoad:    state_d = StCompute;
      StCompute: if (issue_last) state_d = StDrain;
      StDrain:   if (drain_last) state_d = StRead;
      StRead:    state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Counters sit at zero outside COMPUTE so addresses idle at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (state_q == StCompute) begin
      if (k_last) begin
        k_q <= '0;
        if (j_last) begin
          j_q <= '0;
          i_q <= i_last ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + JW'(1);
        end
      end else begin
        k_q <= k_q + KW'(1);
      end
    end else begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_q <= '0;
    end else if (state_q == StDrain) begin
      drain_q <= drain_q + DrainCntW'(1);
    end else begin
      drain_q <= '0;
    end
  end

  always_comb begin
    busy   = (state_q != StIdle);
    a_b_we = (state_q == StLoad);
    a_b_re = (state_q == StCompute);
    c_re   = (state_q == StRead);
    done   = (state_q == StDone);
    a_addr = AW'(32'(i_q) * param_K + 32'(k_q));
    b_addr = BW'(32'(k_q) * param_N + 32'(j_q));
  end

  mac_pipe #(
    .DATA_WIDTH_INITIAL(DATA_WIDTH_INITIAL),
    .DATA_WIDTH_FINAL  (DATA_WIDTH_FINAL),
    .CW                (CW)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .issue     (a_b_re),
    .first     (k_q == '0),
    .last      (k_last),
    .c_idx     (c_idx),
    .a_data_in (a_data_in),
    .b_data_in (b_data_in),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_data_out(c_data_out)
  );

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: default 4x4x4 instance plus a K=1, 2x2 instance, each fed by a memory model.
module tb_mac_sequencer;

  typedef struct packed {
    logic [15:0][7:0]  a;
    logic [15:0][7:0]  b;
    logic [15:0][15:0] c;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start, s_start;
  logic        busy, done, a_b_we, a_b_re, c_we, c_re;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [7:0]  a_data_in, b_data_in;
  logic [15:0] c_data_out;
  logic        s_busy, s_done, s_a_b_we, s_a_b_re, s_c_we, s_c_re;
  logic [0:0]  s_a_addr, s_b_addr;
  logic [1:0]  s_c_addr;
  logic [7:0]  s_a_data_in, s_b_data_in;
  logic [15:0] s_c_data_out;

  always #5 clk = ~clk;

  mac_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .a_b_we(a_b_we), .a_b_re(a_b_re), .a_addr(a_addr), .b_addr(b_addr),
    .a_data_in(a_data_in), .b_data_in(b_data_in), .c_we(c_we), .c_addr(c_addr),
    .c_data_out(c_data_out), .c_re(c_re)
  );

  mac_sequencer #(.param_M(2), .param_K(1), .param_N(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .a_b_we(s_a_b_we), .a_b_re(s_a_b_re), .a_addr(s_a_addr), .b_addr(s_b_addr),
    .a_data_in(s_a_data_in), .b_data_in(s_b_data_in), .c_we(s_c_we), .c_addr(s_c_addr),
    .c_data_out(s_c_data_out), .c_re(s_c_re)
  );

  // Memory-unit models: buffers load on a_b_we, reads are registered.
  logic [15:0][7:0] mat_a, mat_b;
  logic [7:0]       mem_a [16];
  logic [7:0]       mem_b [16];
  logic [1:0][7:0]  s_mat_a, s_mat_b;
  logic [7:0]       s_mem_a [2];
  logic [7:0]       s_mem_b [2];

  always @(posedge clk) begin
    if (a_b_we) for (int x = 0; x < 16; x++) begin
      mem_a[x] <= mat_a[x];
      mem_b[x] <= mat_b[x];
    end
    if (a_b_re) begin
      a_data_in <= mem_a[a_addr];
      b_data_in <= mem_b[b_addr];
    end
    if (s_a_b_we) for (int x = 0; x < 2; x++) begin
      s_mem_a[x] <= s_mat_a[x];
      s_mem_b[x] <= s_mat_b[x];
    end
    if (s_a_b_re) begin
      s_a_data_in <= s_mem_a[s_a_addr];
      s_b_data_in <= s_mem_b[s_b_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc, nwr, ndone, done_first, done_last, cre_cyc, last_we;
  int nwe, we_first, we_last, busy_n, busy_first, busy_last, addr_err;
  int s_nwr, s_done_cyc;
  logic [3:0]  wr_addr [64];
  logic [15:0] wr_data [64];
  logic [1:0]  s_wr_addr [8];
  logic [15:0] s_wr_data [8];
  int          s_wr_cyc [8];
  vec_t        vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    cyc = 0; nwr = 0; ndone = 0; done_first = -1; done_last = -1; cre_cyc = -1;
    last_we = -1; nwe = 0; we_first = -1; we_last = -1; busy_n = 0; busy_first = -1;
    busy_last = -1; addr_err = 0; s_nwr = 0; s_done_cyc = -1;
  endtask

  // Advance one cycle and log outputs at the falling edge; cycle n follows edge n-1.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (c_we) begin
      if (nwr < 64) begin
        wr_addr[nwr] = c_addr;
        wr_data[nwr] = c_data_out;
      end
      nwr++;
      last_we = cyc;
    end
    if (done) begin
      if (ndone == 0) done_first = cyc;
      done_last = cyc;
      ndone++;
    end
    if (c_re) cre_cyc = cyc;
    if (a_b_we) begin
      if (nwe == 0) we_first = cyc;
      we_last = cyc;
      nwe++;
    end
    if (busy) begin
      if (busy_n == 0) busy_first = cyc;
      busy_last = cyc;
      busy_n++;
    end
    if (cyc >= 2 && cyc <= 5 && (a_addr != 4'(cyc - 2) || b_addr != 4'((cyc - 2) * 4)))
      addr_err++;
    if (s_c_we) begin
      if (s_nwr < 8) begin
        s_wr_addr[s_nwr] = s_c_addr;
        s_wr_data[s_nwr] = s_c_data_out;
        s_wr_cyc[s_nwr]  = cyc;
      end
      s_nwr++;
    end
    if (s_done) s_done_cyc = cyc;
  endtask

  task automatic check_writes(input int v, input int base);
    for (int x = 0; x < 16; x++)
      chk($sformatf("v%0d write %0d addr/data", v, base + x),
          {44'd0, wr_addr[base + x], wr_data[base + x]}, {44'd0, 4'(x), vecs[v].c[x]});
  endtask

  task automatic run_job(input int v);
    mat_a = vecs[v].a;
    mat_b = vecs[v].b;
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (74) step();
    chk($sformatf("v%0d c_we count", v), 64'(nwr), 64'd16);
    check_writes(v, 0);
    chk($sformatf("v%0d last c_we cycle", v), 64'(last_we), 64'd68);
    chk($sformatf("v%0d c_re cycle", v), 64'(cre_cyc), 64'd69);
    chk($sformatf("v%0d done cycle", v), 64'(done_first), 64'd70);
    chk($sformatf("v%0d done count", v), 64'(ndone), 64'd1);
    chk($sformatf("v%0d busy span", v), {16'(busy_first), 16'(busy_last), 32'(busy_n)},
        {16'd1, 16'd70, 32'd70});
    chk($sformatf("v%0d load cycle", v), {32'(we_first), 32'(nwe)}, {32'd1, 32'd1});
    chk($sformatf("v%0d addr errors cyc 2..5", v), 64'(addr_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int x = 0; x < 16; x++) begin
      vecs[0].a[x] = (x % 5 == 0) ? 8'd1 : 8'd0;  // identity
      vecs[0].b[x] = 8'(x);
      vecs[0].c[x] = 16'(x);
      vecs[1].a[x] = 8'd255;
      vecs[1].b[x] = 8'd255;
      vecs[1].c[x] = 16'hF804;
      vecs[2].a[x] = (x < 4) ? 8'(x + 1) : 8'd0;
      vecs[2].b[x] = (x % 4 == 0) ? 8'(5 + x / 4) : 8'd0;
      vecs[2].c[x] = (x == 0) ? 16'd70 : 16'd0;
      vecs[3].a[x] = 8'd1;
      vecs[3].b[x] = 8'd2;
      vecs[3].c[x] = 16'd8;
    end
    s_mat_a = {8'd5, 8'd3};
    s_mat_b = {8'd11, 8'd7};

    rst = 1'b1; start = 1'b0; s_start = 1'b0;
    mat_a = '0; mat_b = '0;
    clear_logs();
    repeat (3) step();
    chk("reset outputs", {30'd0, busy, done, a_b_we, a_b_re, c_we, c_re, a_addr, b_addr,
                          c_addr, c_data_out}, 64'd0);
    rst = 1'b0;
    step();
    chk("idle outputs after reset", {58'd0, busy, done, a_b_we, a_b_re, c_we, c_re}, 64'd0);

    for (int v = 0; v < 4; v++) run_job(v);

    // start held high across two jobs; DONE ignores it, IDLE picks it up.
    mat_a = vecs[0].a;
    mat_b = vecs[0].b;
    clear_logs();
    start = 1'b1;
    repeat (80) step();
    start = 1'b0;
    repeat (75) step();
    chk("held start a_b_we count", 64'(nwe), 64'd2);
    chk("held start load cycles", {32'(we_first), 32'(we_last)}, {32'd1, 32'd72});
    chk("held start done cycles", {32'(done_first), 32'(done_last)}, {32'd70, 32'd141});
    chk("held start c_we count", 64'(nwr), 64'd32);
    check_writes(0, 16);

    // Reset mid-job in cycle 30.
    mat_a = vecs[3].a;
    mat_b = vecs[3].b;
    clear_logs();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    begin
      int nwr_before;
      nwr_before = nwr;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("outputs after mid-job reset", {30'd0, busy, done, a_b_we, a_b_re, c_we, c_re,
                                          a_addr, b_addr, c_addr, c_data_out}, 64'd0);
      repeat (40) step();
      chk("no c_we after reset", 64'(nwr), 64'(nwr_before));
      chk("no done/c_re after reset", {32'(ndone), 32'(busy_last)}, {32'd0, 32'd30});
    end
    run_job(2);

    // K=1, 2x2 instance: every issue writes directly.
    clear_logs();
    s_start = 1'b1;
    step();
    s_start = 1'b0;
    repeat (14) step();
    chk("k1 c_we count", 64'(s_nwr), 64'd4);
    for (int x = 0; x < 4; x++) begin
      logic [15:0] exp_c;
      exp_c = 16'(s_mat_a[x / 2]) * 16'(s_mat_b[x % 2]);
      chk($sformatf("k1 write %0d addr/data/cycle", x),
          {14'd0, s_wr_addr[x], s_wr_data[x], 32'(s_wr_cyc[x])},
          {14'd0, 2'(x), exp_c, 32'(5 + x)});
    end
    chk("k1 done cycle", 64'(s_done_cyc), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
